// File: rtl/display_pkg.sv
// Shared display constants and the blank-aware digit search used by the scan
// counter and the segment-data mux.
package display_pkg;

   localparam int   MAX_DIGITS   = 16;
   localparam logic ANODE_ACTIVE = 1'b0;

   typedef struct packed {
      logic       found;
      logic [3:0] next;
      logic       wrapped;
   } scan_next_t;

   // Candidates are visited sel+-1, sel+-2, ... mod n; sel itself is the last candidate.
   function automatic scan_next_t next_unblanked(
      input logic [3:0]            sel,
      input logic [MAX_DIGITS-1:0] mask,
      input logic                  dir,
      input logic [4:0]            n
   );
      scan_next_t r;
      int         c;
      r = '0;
      c = 0;
      for (int i = 1; i <= MAX_DIGITS; i++) begin
         if (!r.found && (i <= int'(n))) begin
            if (dir) c = int'(sel) + int'(n) - i;
            else     c = int'(sel) + i;
            if (c >= int'(n)) c = c - int'(n);
            if (!mask[c[3:0]]) begin
               r.found = 1'b1;
               r.next  = c[3:0];
            end
         end
      end
      if (r.found) r.wrapped = dir ? (r.next >= sel) : (r.next <= sel);
      return r;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler: emits one step every PRESCALE enabled clock cycles.
module scan_prescaler
   import display_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic step
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign step = en && (count_q == TERM);

   always_comb begin
      count_d = count_q;
      if (en) count_d = step ? '0 : count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

endmodule

// File: rtl/digit_scan_counter.sv
// Seven-segment digit scanner: prescaled up/down digit select that skips
// blanked digits, with active-low anode decode and tick/wrap strobes.
module digit_scan_counter
   import display_pkg::*;
#(
   parameter  int NUM_DIGITS = 8,
   parameter  int PRESCALE   = 4,
   localparam int SEL_W      = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  dir,
   input  logic [NUM_DIGITS-1:0] blank_mask,
   output logic [SEL_W-1:0]      sel,
   output logic [NUM_DIGITS-1:0] anode_n,
   output logic                  tick,
   output logic                  wrap
);

   logic             step;
   scan_next_t       res;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic             unused_next_bits;

   scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .step (step)
   );

   assign res = next_unblanked(4'(sel_q), MAX_DIGITS'(blank_mask), dir, 5'(NUM_DIGITS));
   assign unused_next_bits = ^res.next;

   // An all-blanked step still consumes the prescaler interval but leaves sel alone.
   always_comb begin
      sel_d  = sel_q;
      tick_d = 1'b0;
      wrap_d = 1'b0;
      if (step && res.found) begin
         sel_d  = res.next[SEL_W-1:0];
         tick_d = 1'b1;
         wrap_d = res.wrapped;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q  <= '0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         sel_q  <= sel_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
      end
   end

   always_comb begin
      anode_n = {NUM_DIGITS{~ANODE_ACTIVE}};
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((SEL_W'(i) == sel_q) && !blank_mask[i]) anode_n[i] = ANODE_ACTIVE;
      end
   end

   assign sel  = sel_q;
   assign tick = tick_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_digit_scan_counter.sv
// Directed bench for digit_scan_counter: 8-digit/prescale-4 and 6-digit/prescale-1 instances.
module tb_digit_scan_counter;

   logic       clk;
   logic       rst, en, dir;
   logic [7:0] mask;
   logic [2:0] sel;
   logic [7:0] anode_n;
   logic       tick, wrap;

   logic       rst6, en6, dir6;
   logic [5:0] mask6;
   logic [2:0] sel6;
   logic [5:0] anode6;
   logic       tick6, wrap6;

   int n_checks = 0;
   int n_pass   = 0;
   int ticks_seen;

   digit_scan_counter #(.NUM_DIGITS(8), .PRESCALE(4)) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .blank_mask(mask),
      .sel(sel), .anode_n(anode_n), .tick(tick), .wrap(wrap)
   );

   digit_scan_counter #(.NUM_DIGITS(6), .PRESCALE(1)) dut6 (
      .clk(clk), .rst(rst6), .en(en6), .dir(dir6), .blank_mask(mask6),
      .sel(sel6), .anode_n(anode6), .tick(tick6), .wrap(wrap6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else             n_pass++;
   endtask

   function automatic logic [7:0] an8(input int s, input logic [7:0] m);
      logic [7:0] oh;
      oh = 8'b1 << s;
      return ~(oh & ~m);
   endfunction

   // Three quiet cycles, then the step cycle with new sel and strobes.
   task automatic step_check(input string tag, input int exp_sel, input logic exp_wrap);
      repeat (3) @(negedge clk);
      check({tag, "_pretick"}, 32'(tick), 32'd0);
      @(negedge clk);
      check({tag, "_sel"},   32'(sel),     32'(exp_sel));
      check({tag, "_tick"},  32'(tick),    32'd1);
      check({tag, "_wrap"},  32'(wrap),    32'(exp_wrap));
      check({tag, "_anode"}, 32'(anode_n), 32'(an8(exp_sel, mask)));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; dir = 1'b0; mask = 8'h00;
      rst6 = 1'b1; en6 = 1'b0; dir6 = 1'b0; mask6 = 6'h00;
      repeat (2) @(negedge clk);
      check("rst_sel",   32'(sel),     32'd0);
      check("rst_tick",  32'(tick),    32'd0);
      check("rst_wrap",  32'(wrap),    32'd0);
      check("rst_anode", 32'(anode_n), 32'hFE);

      // ascending frame
      rst = 1'b0; en = 1'b1;
      for (int k = 1; k <= 8; k++) step_check($sformatf("up%0d", k), k % 8, k == 8);

      // descending from 0 wraps to 7
      dir = 1'b1;
      step_check("dn7", 7, 1'b1);
      step_check("dn6", 6, 1'b0);
      step_check("dn5", 5, 1'b0);

      // reset with a step pending
      repeat (3) @(negedge clk);
      rst = 1'b1; dir = 1'b0;
      @(negedge clk);
      check("midrst_sel",  32'(sel),  32'd0);
      check("midrst_tick", 32'(tick), 32'd0);
      check("midrst_wrap", 32'(wrap), 32'd0);
      rst = 1'b0;
      step_check("postrst", 1, 1'b0);

      // blanked digits skipped
      mask = 8'b0110_1100;
      step_check("skip4", 4, 1'b0);
      step_check("skip7", 7, 1'b0);
      step_check("skip0", 0, 1'b1);
      step_check("skip1", 1, 1'b0);

      // all blanked
      mask = 8'hFF;
      ticks_seen = 0;
      repeat (32) begin
         @(negedge clk);
         if (tick || wrap) ticks_seen++;
      end
      check("allblank_ticks", 32'(ticks_seen), 32'd0);
      check("allblank_sel",   32'(sel),        32'd1);
      check("allblank_anode", 32'(anode_n),    32'hFF);

      // single unblanked digit
      mask = 8'hEF;
      step_check("single4a", 4, 1'b0);
      step_check("single4b", 4, 1'b1);
      step_check("single4c", 4, 1'b1);

      // freeze mid-interval at prescaler=2
      mask = 8'h00;
      repeat (2) @(negedge clk);
      en = 1'b0;
      ticks_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (tick || wrap || (sel != 3'd4)) ticks_seen++;
      end
      check("frozen_activity", 32'(ticks_seen), 32'd0);
      check("frozen_anode",    32'(anode_n),    32'hEF);
      en = 1'b1;
      @(negedge clk);
      check("resume_quiet", 32'(tick), 32'd0);
      @(negedge clk);
      check("resume_sel",  32'(sel),  32'd5);
      check("resume_tick", 32'(tick), 32'd1);

      // blank the current digit between steps
      @(negedge clk);
      mask = 8'h20;
      #1;
      check("blankcur_anode", 32'(anode_n), 32'hFF);
      check("blankcur_sel",   32'(sel),     32'd5);
      repeat (2) @(negedge clk);
      check("blankcur_quiet", 32'(tick), 32'd0);
      @(negedge clk);
      check("blankcur_sel6", 32'(sel),  32'd6);
      check("blankcur_tick", 32'(tick), 32'd1);
      check("blankcur_wrap", 32'(wrap), 32'd0);

      // direction changed mid-interval; 5 still blanked
      @(negedge clk);
      dir = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk);
      check("dirchg_sel",  32'(sel),  32'd4);
      check("dirchg_tick", 32'(tick), 32'd1);
      check("dirchg_wrap", 32'(wrap), 32'd0);

      // 6 digits, step every cycle
      check("n6_rst_sel",   32'(sel6),   32'd0);
      check("n6_rst_anode", 32'(anode6), 32'h3E);
      rst6 = 1'b0; en6 = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         check($sformatf("n6_sel%0d", k),  32'(sel6),  32'(k % 6));
         check($sformatf("n6_tick%0d", k), 32'(tick6), 32'd1);
         check($sformatf("n6_wrap%0d", k), 32'(wrap6), 32'((k % 6) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
